// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int FETCH_ADDR_W = 32;
    localparam int FETCH_DATA_W = 32;
    localparam int INSTR_BYTES  = 4;

    // One queued instruction together with the address it was fetched from.
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

    // Sequential PC step; wraps modulo 2^FETCH_ADDR_W.
    function automatic logic [FETCH_ADDR_W-1:0] pc_next(input logic [FETCH_ADDR_W-1:0] pc);
        return pc + FETCH_ADDR_W'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with push/pop/flush and occupancy count.
// Latency: a push is visible at head_o on the following cycle.
// Backpressure: push when full and pop when empty are ignored; flush wins over push/pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    // Status flags and qualified push/pop.
    always_comb begin
        full_o  = (count_q == DEPTH_C);
        empty_o = (count_q == '0);
        count_o = count_q;
        head_o  = mem_q[rd_ptr_q];
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
    end

    // Pointer and count update; flush empties the queue in one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array; contents are don't-care outside the valid window.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues in-order word requests, queues returned instructions for decode.
// Latency: memory-defined request->response; response->instr_valid is one cycle.
// Backpressure: requests are credit-limited (queued + in flight <= FIFO_DEPTH); decode stalls via instr_ready.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = FETCH_DATA_W,
    parameter int                    ADDR_WIDTH = FETCH_ADDR_W,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(FIFO_DEPTH);

    logic                  rst_q;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]         outstanding_q, outstanding_d;
    logic [CW-1:0]         drop_cnt_q, drop_cnt_d;

    logic [CW-1:0]         fifo_count;
    logic                  fifo_full, fifo_empty;
    fetch_entry_t          push_entry, head_entry;
    logic [CW:0]           credits_used;
    logic                  req_hs, rsp_drop, push, pop;

    // Credit check, handshakes and the drop decision for this cycle.
    always_comb begin
        credits_used   = {1'b0, outstanding_q} + {1'b0, fifo_count};
        imem_req_valid = !rst && !rst_q && !redirect_valid && (credits_used < CREDIT_LIMIT);
        imem_req_addr  = fetch_pc_q;
        req_hs         = imem_req_valid && imem_req_ready;
        rsp_drop       = imem_rsp_valid && (drop_cnt_q != '0);
        push           = imem_rsp_valid && !rsp_drop;
        push_entry.pc    = rsp_pc_q;
        push_entry.instr = imem_rsp_data;
        instr_valid    = !rst && !fifo_empty;
        instr          = head_entry.instr;
        instr_pc       = head_entry.pc;
        pop            = instr_valid && instr_ready;
    end

    // Next PCs and counters; a redirect overrides everything and marks all in-flight requests stale.
    always_comb begin
        outstanding_d = outstanding_q + CW'(req_hs) - CW'(imem_rsp_valid);
        drop_cnt_d    = drop_cnt_q - CW'(rsp_drop);
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        if (req_hs) fetch_pc_d = pc_next(fetch_pc_q);
        if (push)   rsp_pc_d   = pc_next(rsp_pc_q);
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            drop_cnt_d = outstanding_d;
        end
    end

    // State registers; rst_q keeps requests off for one cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_q         <= 1'b1;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            rst_q         <= 1'b0;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_queue (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head_entry),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // The credit rule makes these impossible with a well-behaved memory.
    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));
    a_rsp_expected: assert property (@(posedge clk) disable iff (rst) imem_rsp_valid |-> (outstanding_q != '0));
    a_drop_bound:   assert property (@(posedge clk) disable iff (rst) drop_cnt_q <= outstanding_q);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed table, corner sequences, randomized traffic vs a queue model.
// Latency: memory model responds a configurable 1..4 cycles after each accepted request, in order.
// Backpressure: request ready and decode ready are driven per cycle (fixed or random).
module tb_instr_fetch;

    localparam int          DEPTH   = 4;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_ready = 1'b0;
    logic        imem_req_valid, instr_valid;
    logic [31:0] imem_req_addr, instr, instr_pc;

    logic        w_req_valid, w_instr_valid;
    logic [31:0] w_req_addr, w_instr, w_instr_pc;

    instr_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
    );

    // Second instance near the top of the address space; never answered, so it issues exactly DEPTH requests.
    instr_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(WRAP_PC), .FIFO_DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst(rst), .redirect_valid(1'b0), .redirect_pc(32'h0),
        .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
        .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
        .instr_valid(w_instr_valid), .instr_ready(1'b0), .instr(w_instr), .instr_pc(w_instr_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          live;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    pend_t       pend[$];
    entry_t      m_q[$];
    logic [31:0] m_fetch_pc = '0;
    bit          last_rst = 1'b1;
    bit          w_rec = 1'b0;
    logic [31:0] w_seen[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, let the memory answer, check against the model, advance the model.
    task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic rq, input logic ir);
        bit    exp_rv, exp_iv, rsp_now;
        pend_t p;
        @(negedge clk);
        rst            = r;
        redirect_valid = rd;
        redirect_pc    = rpc;
        imem_req_ready = rq;
        instr_ready    = ir;
        rsp_now        = !r && (pend.size() > 0) && (pend[0].due <= cyc);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? mem_word(pend[0].addr) : 32'h0;
        #1;
        exp_rv = !r && !last_rst && !rd && ((pend.size() + m_q.size()) < DEPTH);
        exp_iv = !r && (m_q.size() != 0);
        cmp("req_valid", imem_req_valid, exp_rv);
        if (exp_rv) cmp("req_addr", imem_req_addr, m_fetch_pc);
        cmp("instr_valid", instr_valid, exp_iv);
        if (exp_iv) begin
            cmp("instr_pc", instr_pc, m_q[0].pc);
            cmp("instr", instr, m_q[0].word);
        end
        if (w_rec && w_req_valid) w_seen.push_back(w_req_addr);
        if (r) begin
            pend.delete();
            m_q.delete();
            m_fetch_pc = 32'h0;
        end else begin
            if (exp_iv && ir) void'(m_q.pop_front());
            if (rsp_now) begin
                p = pend.pop_front();
                if (p.live) m_q.push_back(entry_t'{p.addr, mem_word(p.addr)});
            end
            if (exp_rv && rq) begin
                pend.push_back(pend_t'{m_fetch_pc, cyc + int'($urandom_range(lat_min, lat_max)), 1'b1});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
            if (rd) begin
                m_q.delete();
                foreach (pend[i]) pend[i].live = 1'b0;
                m_fetch_pc = rpc;
            end
        end
        last_rst = r;
        cyc++;
    endtask

    typedef struct {
        bit          r;
        bit          ir;
        bit          rv;
        logic [31:0] addr;
        bit          iv;
        logic [31:0] ipc;
    } vec_t;

    vec_t        tbl[14];
    bit          got;
    logic [31:0] a0;

    initial begin
        // Zero-wait memory from reset with decode stalled, then released: fill to DEPTH, drain, resume at 0x10.
        tbl[0]  = '{1, 0, 0, 32'h00, 0, 32'h00};
        tbl[1]  = '{0, 0, 0, 32'h00, 0, 32'h00};
        tbl[2]  = '{0, 0, 1, 32'h00, 0, 32'h00};
        tbl[3]  = '{0, 0, 1, 32'h04, 0, 32'h00};
        tbl[4]  = '{0, 0, 1, 32'h08, 1, 32'h00};
        tbl[5]  = '{0, 0, 1, 32'h0C, 1, 32'h00};
        tbl[6]  = '{0, 0, 0, 32'h00, 1, 32'h00};
        tbl[7]  = '{0, 0, 0, 32'h00, 1, 32'h00};
        tbl[8]  = '{0, 1, 0, 32'h00, 1, 32'h00};
        tbl[9]  = '{0, 1, 1, 32'h10, 1, 32'h04};
        tbl[10] = '{0, 1, 1, 32'h14, 1, 32'h08};
        tbl[11] = '{0, 1, 1, 32'h18, 1, 32'h0C};
        tbl[12] = '{0, 1, 1, 32'h1C, 1, 32'h10};
        tbl[13] = '{0, 1, 1, 32'h20, 1, 32'h14};

        lat_min = 1; lat_max = 1;
        w_rec = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].r, 1'b0, 32'h0, 1'b1, tbl[i].ir);
            cmp("tbl_req_valid", imem_req_valid, tbl[i].rv);
            if (tbl[i].rv) cmp("tbl_req_addr", imem_req_addr, tbl[i].addr);
            cmp("tbl_instr_valid", instr_valid, tbl[i].iv);
            if (tbl[i].iv) cmp("tbl_instr_pc", instr_pc, tbl[i].ipc);
        end
        w_rec = 1'b0;

        // PC wrap on the second instance.
        cmp("wrap_req_count", w_seen.size(), 4);
        if (w_seen.size() >= 4) begin
            cmp("wrap_addr0", w_seen[0], 32'hFFFF_FFF8);
            cmp("wrap_addr1", w_seen[1], 32'hFFFF_FFFC);
            cmp("wrap_addr2", w_seen[2], 32'h0000_0000);
            cmp("wrap_addr3", w_seen[3], 32'h0000_0004);
        end
        cmp("wrap_no_instr", w_instr_valid, 1'b0);

        // Latency-3 memory; redirect while 0x8/0xC are in flight, 0x4 arrives and head 0x0 is popped.
        lat_min = 3; lat_max = 3;
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 32'h100, 1'b1, 1'b1);
        cmp("redir_cycle_req_valid", imem_req_valid, 1'b0);
        cmp("redir_cycle_head_valid", instr_valid, 1'b1);
        cmp("redir_cycle_head_pc", instr_pc, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        cmp("redir_next_req_valid", imem_req_valid, 1'b1);
        cmp("redir_next_req_addr", imem_req_addr, 32'h100);
        cmp("redir_next_queue_empty", instr_valid, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            if (instr_valid) begin
                got = 1'b1;
                cmp("redir_first_pc", instr_pc, 32'h100);
                cmp("redir_first_instr", instr, mem_word(32'h100));
            end
        end
        cmp("redir_first_seen", got, 1'b1);

        // Request stall: address held while ready is low, then a redirect moves it.
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            got = imem_req_valid;
        end
        cmp("stall_req_seen", got, 1'b1);
        a0 = m_fetch_pc;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            cmp("stall_req_valid", imem_req_valid, 1'b1);
            cmp("stall_req_addr", imem_req_addr, a0);
        end
        step(1'b0, 1'b1, 32'h2000, 1'b0, 1'b1);
        cmp("stall_redir_req_valid", imem_req_valid, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        cmp("stall_redir_req_valid_next", imem_req_valid, 1'b1);
        cmp("stall_redir_req_addr", imem_req_addr, 32'h2000);

        // Reset with three entries queued and one request outstanding.
        lat_min = 1; lat_max = 1;
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cmp("prerst_head_valid", instr_valid, 1'b1);
        cmp("prerst_head_pc", instr_pc, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cmp("postrst_instr_valid", instr_valid, 1'b0);
        cmp("postrst_req_valid", imem_req_valid, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cmp("postrst_first_valid", imem_req_valid, 1'b1);
        cmp("postrst_first_addr", imem_req_addr, 32'h0);

        // Randomized traffic against the queue model.
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            logic        r, rd, rq, ir;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 299) == 0);
            rd  = ($urandom_range(0, 15) == 0);
            rq  = ($urandom_range(0, 3) != 0);
            ir  = ($urandom_range(0, 3) != 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                              : ($urandom & 32'hFFFF_FFFC);
            step(r, rd, rpc, rq, ir);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
